// File: rtl/handshake_arbiter.sv
// Two-requester round-robin arbiter driving a four-phase req/ack handshake to device B.
// Optional timeout/abort logic is compiled in with HANDSHAKE_TIMEOUT_EN.
module handshake_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic send0,
    input  logic send1,
    input  logic devB,
    output logic devA,
    output logic owner,
    output logic busy,
    output logic done0,
    output logic done1,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
`ifdef HANDSHAKE_TIMEOUT_EN
        ,
        ERR  = 2'd3
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] pending_q, pending_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic       devA_q, devA_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       grant_sel;
`ifdef HANDSHAKE_TIMEOUT_EN
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | {send1, send0};
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        devA_d       = devA_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        grant_sel    = 1'b0;
`ifdef HANDSHAKE_TIMEOUT_EN
        err_d        = err_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_sel    = (pending_q == 2'b11) ? ~last_owner_q : pending_q[1];
                    owner_d      = grant_sel;
                    last_owner_d = grant_sel;
                    // A send arriving in the grant cycle re-arms the bit just cleared.
                    pending_d[grant_sel] = grant_sel ? send1 : send0;
                    state_d      = REQ;
                    devA_d       = 1'b1;
                end
            end
            REQ: begin
                if (devB) begin
                    state_d = ACK;
                    devA_d  = 1'b0;
                end
            end
            ACK: begin
                if (!devB) begin
                    state_d = IDLE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end
            end
`ifdef HANDSHAKE_TIMEOUT_EN
            ERR: begin
                if (!devB) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef HANDSHAKE_TIMEOUT_EN
        // A regular handshake step in the same cycle takes precedence over the abort.
        if ((state_q == REQ || state_q == ACK) && state_d == state_q
            && cnt_q == TIMEOUT_CYCLES - 16'd1) begin
            state_d = ERR;
            devA_d  = 1'b0;
            err_d   = 1'b1;
        end
        if (state_d != state_q)
            cnt_d = 16'd0;
        else if (state_q == REQ || state_q == ACK)
            cnt_d = cnt_q + 16'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 2'b00;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            devA_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
`ifdef HANDSHAKE_TIMEOUT_EN
            err_q        <= 1'b0;
            cnt_q        <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            devA_q       <= devA_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
`ifdef HANDSHAKE_TIMEOUT_EN
            err_q        <= err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign devA  = devA_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);
    assign done0 = done0_q;
    assign done1 = done1_q;

`ifdef HANDSHAKE_TIMEOUT_EN
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

endmodule
